arbitro_vc: RTL and testbench
=============================

Name: arbitro_vc

Overview:
- Consumer stage directly downstream of the per-VC transmit FIFOs (VC0, VC1).
- Pops words under strict VC0-over-VC1 priority and routes each word by a destination bit to one of two destination FIFOs (D0, D1).
- Respects destination almost-full backpressure, using each VC FIFO's head-peek word to learn the destination before popping.
- Keeps per-destination word counters and reports idle status to the transmission-layer control logic.

Parameters:
- data_width, 6, width of every data word.
- dest_bit, 4, index of the bit in a word that selects D0 (0) or D1 (1).
- cnt_width, 5, width of each per-destination word counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous active-low reset.
- init  in  1  synchronous active-low soft clear, same sense as the FIFOs' init.
- empty_VC0, empty_VC1  in  1 each  VC FIFO empty flags.
- data_arbitro_VC0, data_arbitro_VC1  in  data_width each  registered head-peek words from the VC FIFOs.
- data_out_VC0, data_out_VC1  in  data_width each  FIFO read data, valid one cycle after the pop.
- almost_full_D0, almost_full_D1  in  1 each  destination FIFO backpressure.
- pop_VC0, pop_VC1  out  1 each  read enables to the VC FIFOs (combinational).
- push_D0, push_D1  out  1 each  write enables to the destination FIFOs (registered).
- data_D0, data_D1  out  data_width each  write data (registered).
- cnt_D0, cnt_D1  out  cnt_width each  words pushed per destination (registered).
- idle  out  1  high in state IDLE.

Behaviour:
- Reset (async, reset=0): state=INIT. All registered outputs are 0; the sel pipeline is cleared.
- init=0 at any clock edge: state=INIT and the same clear as reset. In-flight words are dropped. pop_VC0=pop_VC1=0 while in INIT.
- FSM transitions:
  - INIT to IDLE when init=1.
  - IDLE to ACTIVE when empty_VC0=0 or empty_VC1=0.
  - ACTIVE to IDLE when both empties are 1, no pop is issued this cycle, sel_valid=0, and both pushes are 0.
  - idle = (state==IDLE). Pops are allowed in IDLE and ACTIVE.
- Head destination:
  - dVC0 = data_arbitro_VC0[dest_bit]; dVC1 = data_arbitro_VC1[dest_bit].
  - blkx = almost_full_D(dVCx).
- Peek staleness rule: a VC FIFO's peek register lags its read pointer by one cycle. A VC that was popped in cycle N is therefore ineligible in N+1 (holdx = registered pop_VCx).
- Pop equations:
  - pop_VC0 = run & ~empty_VC0 & ~blk0 & ~hold0.
  - pop_VC1 = run & ~pop_VC0 & ~empty_VC1 & ~blk1 & ~hold1.
  - At most one pop per cycle.
  - VC1 may bypass a VC0 head that is blocked by backpressure.
- Pipeline timing:
  - Cycle N: pop_VCx=1. At the end of N, register sel_valid=1, sel_vc=x.
  - Cycle N+1: word = sel_vc ? data_out_VC1 : data_out_VC0, and d = word[dest_bit].
  - At the end of N+1: push_Dd<=1, data_Dd<=word, cnt_Dd<=cnt_Dd+1 (wraps modulo 2^cnt_width). The other push goes to 0; the other data output holds its value.
  - Pop-to-push latency is 2 cycles. Sustained throughput is 1 word/cycle only when VCs alternate; a single VC sustains 1 word every 2 cycles.
- Backpressure margin: up to 2 words can be in flight after almost_full rises. The destination FIFO threshold must leave at least 2 free slots.
- Simultaneous events:
  - empty and almost_full inputs are sampled combinationally in the same cycle.
  - init=0 overrides all activity.
  - A push in flight completes even if almost_full rises in N+1.

Decomposition:
- Shared package holds the state encodings (INIT, IDLE, ACTIVE) and the default dest_bit and cnt_width constants.
- No sub-module. The pop logic, the 2-stage sel/push pipeline and the counters fit in one module.

Test Plan:
- Reset/init: assert reset=0 mid-push → all outputs 0 immediately. Release reset with init=0 → state INIT, pops 0. Set init=1 → idle=1.
- VC0 single word 6'h05 (bit4=0), D0/D1 not full: pop_VC0 in cycle N → push_D0=1, data_D0=6'h05 at N+2, cnt_D0=1; next pop_VC0 no earlier than N+2.
- Priority: VC0 head 6'h05 and VC1 head 6'h15 both present → pop_VC0 first, pop_VC1 the next cycle. data_D0=6'h05 at N+2, then data_D1=6'h15 at N+3.
- Bypass: almost_full_D0=1, VC0 head 6'h05, VC1 head 6'h15 → only pop_VC1; push_D1 with 6'h15; pop_VC0 stays 0 until almost_full_D0=0.
- Counter wrap: 32 words to D1 → cnt_D1 returns to 0; cnt_D0 unchanged.
- Drain: after the last push, both empty → idle=1 the cycle after push drops. Pulse init=0 with a word in flight → no push occurs and counters are 0.

Source files
------------

// File: rtl/arbitro_vc_pkg.sv
// Shared definitions for the VC arbiter: FSM state encoding and default
// word/counter geometry.
package arbitro_vc_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_t;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int DEST_BIT_DEF   = 4;
    localparam int CNT_WIDTH_DEF  = 5;

endpackage

// File: rtl/arbitro_vc.sv
// Pops the VC0/VC1 transmit FIFOs under strict VC0 priority and routes each word
// to destination FIFO D0 or D1 according to its destination bit.
module arbitro_vc
    import arbitro_vc_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int dest_bit   = DEST_BIT_DEF,
    parameter int cnt_width  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  empty_VC0,
    input  logic                  empty_VC1,
    input  logic [data_width-1:0] data_arbitro_VC0,
    input  logic [data_width-1:0] data_arbitro_VC1,
    input  logic [data_width-1:0] data_out_VC0,
    input  logic [data_width-1:0] data_out_VC1,
    input  logic                  almost_full_D0,
    input  logic                  almost_full_D1,
    output logic                  pop_VC0,
    output logic                  pop_VC1,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [data_width-1:0] data_D0,
    output logic [data_width-1:0] data_D1,
    output logic [cnt_width-1:0]  cnt_D0,
    output logic [cnt_width-1:0]  cnt_D1,
    output logic                  idle
);

    localparam logic [cnt_width-1:0]  CNT_ONE   = {{(cnt_width-1){1'b0}}, 1'b1};
    localparam logic [cnt_width-1:0]  CNT_ZERO  = {cnt_width{1'b0}};
    localparam logic [data_width-1:0] DATA_ZERO = {data_width{1'b0}};

    arb_state_t            state_r;
    arb_state_t            state_next_s;
    logic                  hold0_r;
    logic                  hold1_r;
    logic                  sel_valid_r;
    logic                  sel_vc_r;
    logic                  run_s;
    logic                  blk0_s;
    logic                  blk1_s;
    logic [data_width-1:0] word_s;
    logic                  word_dest_s;
    logic                  unused_s;

    // Only the destination bit of each peek word matters here.
    assign unused_s = ^{data_arbitro_VC0, data_arbitro_VC1};

    // Head-of-line blocking and pop decision; a VC popped last cycle has a stale peek.
    always_comb begin
        run_s   = init & (state_r != ST_INIT);
        blk0_s  = 1'b0;
        blk1_s  = 1'b0;
        if (data_arbitro_VC0[dest_bit]) begin
            blk0_s = almost_full_D1;
        end else begin
            blk0_s = almost_full_D0;
        end
        if (data_arbitro_VC1[dest_bit]) begin
            blk1_s = almost_full_D1;
        end else begin
            blk1_s = almost_full_D0;
        end
        pop_VC0 = run_s & ~empty_VC0 & ~blk0_s & ~hold0_r;
        pop_VC1 = run_s & ~pop_VC0 & ~empty_VC1 & ~blk1_s & ~hold1_r;
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (!empty_VC0 || !empty_VC1) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (empty_VC0 && empty_VC1 && !pop_VC0 && !pop_VC1 &&
                    !sel_valid_r && !push_D0 && !push_D1) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: begin
                state_next_s = ST_INIT;
            end
        endcase
    end

    // Word returned by the FIFO popped last cycle.
    always_comb begin
        word_s = DATA_ZERO;
        if (sel_vc_r) begin
            word_s = data_out_VC1;
        end else begin
            word_s = data_out_VC0;
        end
        word_dest_s = word_s[dest_bit];
    end

    // State register, pop hold flags and the select stage of the pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_INIT;
            hold0_r     <= 1'b0;
            hold1_r     <= 1'b0;
            sel_valid_r <= 1'b0;
            sel_vc_r    <= 1'b0;
        end else if (!init) begin
            state_r     <= ST_INIT;
            hold0_r     <= 1'b0;
            hold1_r     <= 1'b0;
            sel_valid_r <= 1'b0;
            sel_vc_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            hold0_r     <= pop_VC0;
            hold1_r     <= pop_VC1;
            sel_valid_r <= pop_VC0 | pop_VC1;
            sel_vc_r    <= pop_VC1;
        end
    end

    // Push stage: write the selected word into its destination and count it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_D0 <= 1'b0;
            push_D1 <= 1'b0;
            data_D0 <= DATA_ZERO;
            data_D1 <= DATA_ZERO;
            cnt_D0  <= CNT_ZERO;
            cnt_D1  <= CNT_ZERO;
            idle    <= 1'b0;
        end else if (!init) begin
            push_D0 <= 1'b0;
            push_D1 <= 1'b0;
            data_D0 <= DATA_ZERO;
            data_D1 <= DATA_ZERO;
            cnt_D0  <= CNT_ZERO;
            cnt_D1  <= CNT_ZERO;
            idle    <= 1'b0;
        end else begin
            idle <= (state_next_s == ST_IDLE);
            if (sel_valid_r) begin
                if (word_dest_s) begin
                    push_D0 <= 1'b0;
                    push_D1 <= 1'b1;
                    data_D1 <= word_s;
                    cnt_D1  <= cnt_D1 + CNT_ONE;
                end else begin
                    push_D0 <= 1'b1;
                    push_D1 <= 1'b0;
                    data_D0 <= word_s;
                    cnt_D0  <= cnt_D0 + CNT_ONE;
                end
            end else begin
                push_D0 <= 1'b0;
                push_D1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_vc.sv
// Directed and randomized bench for arbitro_vc with VC FIFO models and a
// queue-based scoreboard of expected pops and pushes.
module tb_arbitro_vc;

    logic       clk = 1'b0;
    logic       reset, init;
    logic       empty_VC0, empty_VC1, almost_full_D0, almost_full_D1;
    logic [5:0] data_arbitro_VC0, data_arbitro_VC1, data_out_VC0, data_out_VC1;
    logic       pop_VC0, pop_VC1, push_D0, push_D1, idle;
    logic [5:0] data_D0, data_D1;
    logic [4:0] cnt_D0, cnt_D1;

    always #5 clk = ~clk;

    arbitro_vc dut (
        .clk(clk), .reset(reset), .init(init),
        .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
        .data_arbitro_VC0(data_arbitro_VC0), .data_arbitro_VC1(data_arbitro_VC1),
        .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
        .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
        .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
        .push_D0(push_D0), .push_D1(push_D1),
        .data_D0(data_D0), .data_D1(data_D1),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
        .idle(idle)
    );

    // VC FIFO contents and the reference model
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    bit         run_m, held0, held1, pend_v, exp_v, p0, p1;
    logic [5:0] pend_w, exp_w;
    logic [5:0] last_w [2];
    int         cnt_m [2];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic bit blocked(input logic [5:0] head);
        return head[4] ? almost_full_D1 : almost_full_D0;
    endfunction

    task automatic clear_model();
        run_m = 1'b0; held0 = 1'b0; held1 = 1'b0;
        pend_v = 1'b0; exp_v = 1'b0; pend_w = 6'h00; exp_w = 6'h00;
        last_w[0] = 6'h00; last_w[1] = 6'h00;
        cnt_m[0] = 0; cnt_m[1] = 0;
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic cycle();
        bit         e0, e1, init_s, rst_s;
        logic [5:0] w, pre0, pre1;
        #4;
        e0 = run_m && init && !empty_VC0 && (q0.size() > 0) && !held0 && !blocked(q0[0]);
        e1 = run_m && init && !e0 && !empty_VC1 && (q1.size() > 0) && !held1 && !blocked(q1[0]);
        chk("pop_VC0", pop_VC0, e0);
        chk("pop_VC1", pop_VC1, e1);
        p0 = pop_VC0; p1 = pop_VC1; init_s = init; rst_s = reset;
        @(posedge clk);
        #1;
        pre0 = (q0.size() > 0) ? q0[0] : data_arbitro_VC0;
        pre1 = (q1.size() > 0) ? q1[0] : data_arbitro_VC1;
        w = 6'h00;
        if (p0 && q0.size() > 0) begin w = q0.pop_front(); data_out_VC0 = w; end
        if (p1 && q1.size() > 0) begin w = q1.pop_front(); data_out_VC1 = w; end
        data_arbitro_VC0 = pre0;
        data_arbitro_VC1 = pre1;
        if (!rst_s || !init_s) begin
            q0.delete(); q1.delete();
            clear_model();
        end else begin
            exp_v = pend_v; exp_w = pend_w;
            if (exp_v) begin
                cnt_m[exp_w[4]] = (cnt_m[exp_w[4]] + 1) % 32;
                last_w[exp_w[4]] = exp_w;
            end
            pend_v = p0 | p1; pend_w = w;
            held0 = p0; held1 = p1; run_m = 1'b1;
        end
        empty_VC0 = (q0.size() == 0);
        empty_VC1 = (q1.size() == 0);
        chk("push_D0", push_D0, exp_v && !exp_w[4]);
        chk("push_D1", push_D1, exp_v && exp_w[4]);
        chk("data_D0", data_D0, last_w[0]);
        chk("data_D1", data_D1, last_w[1]);
        chk("cnt_D0", cnt_D0, cnt_m[0][4:0]);
        chk("cnt_D1", cnt_D1, cnt_m[1][4:0]);
        @(negedge clk);
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pend_v || exp_v) && k < maxc) begin
            cycle();
            k++;
        end
        chk("drain_bound", (k < maxc), 1'b1);
        cycle();
        cycle();
    endtask

    initial begin
        int n;
        logic [5:0] w6;
        reset = 1'b0; init = 1'b0;
        empty_VC0 = 1'b1; empty_VC1 = 1'b1;
        almost_full_D0 = 1'b0; almost_full_D1 = 1'b0;
        data_arbitro_VC0 = 6'h00; data_arbitro_VC1 = 6'h00;
        data_out_VC0 = 6'h00; data_out_VC1 = 6'h00;
        clear_model();
        #1;
        chk("rst_push", {push_D0, push_D1}, 2'b00);
        chk("rst_cnt", {cnt_D0, cnt_D1}, 10'h000);
        chk("rst_idle", idle, 1'b0);
        @(negedge clk);
        cycle();
        reset = 1'b1;
        cycle();
        chk("init_idle", idle, 1'b0);
        init = 1'b1;
        cycle();
        chk("idle_after_init", idle, 1'b1);

        // Single VC, two D0 words: second pop no earlier than two cycles later
        q0.push_back(6'h05); q0.push_back(6'h07);
        cycle();
        cycle(); chk("t1_pop_n", p0, 1'b1);
        cycle(); chk("t1_hold", p0, 1'b0);
        chk("t1_push", push_D0, 1'b1); chk("t1_data", data_D0, 6'h05); chk("t1_cnt", cnt_D0, 5'd1);
        cycle(); chk("t1_pop_n2", p0, 1'b1);
        drain(20);

        // VC0 priority over VC1
        q0.push_back(6'h05); q1.push_back(6'h15);
        cycle();
        cycle(); chk("pr_pop0", {p0, p1}, 2'b10);
        cycle(); chk("pr_pop1", {p0, p1}, 2'b01);
        chk("pr_push0", push_D0, 1'b1); chk("pr_data0", data_D0, 6'h05);
        cycle(); chk("pr_push1", {push_D0, push_D1}, 2'b01); chk("pr_data1", data_D1, 6'h15);
        drain(20);

        // VC1 bypasses a VC0 head blocked by D0 backpressure
        almost_full_D0 = 1'b1;
        q0.push_back(6'h05); q1.push_back(6'h15);
        cycle();
        cycle(); chk("bp_pop1", {p0, p1}, 2'b01);
        cycle(); chk("bp_pop0_blk", p0, 1'b0);
        chk("bp_push1", push_D1, 1'b1); chk("bp_data1", data_D1, 6'h15);
        cycle(); chk("bp_pop0_blk2", p0, 1'b0);
        almost_full_D0 = 1'b0;
        cycle(); chk("bp_pop0_free", p0, 1'b1);
        drain(20);

        // Return to idle the cycle after the push drops
        q0.push_back(6'h05);
        cycle();
        cycle(); chk("dr_pop", p0, 1'b1);
        cycle(); chk("dr_push", push_D0, 1'b1); chk("dr_busy", idle, 1'b0);
        cycle(); chk("dr_push_low", push_D0, 1'b0); chk("dr_busy2", idle, 1'b0);
        cycle(); chk("dr_idle", idle, 1'b1);

        // Soft clear with a word in flight drops it
        q0.push_back(6'h05);
        cycle();
        cycle(); chk("ini_pop", p0, 1'b1);
        init = 1'b0;
        cycle(); chk("ini_nopush", push_D0, 1'b0); chk("ini_cnt", {cnt_D0, cnt_D1}, 10'h000);
        chk("ini_idle", idle, 1'b0);
        init = 1'b1;
        cycle(); chk("ini_idle2", idle, 1'b1);
        cycle(); chk("ini_nopush2", push_D0, 1'b0);

        // 32 words to D1 over alternating VCs: counter wraps to 0
        for (int i = 0; i < 32; i++) begin
            w6 = 6'($urandom_range(0, 63)) | 6'h10;
            if (i % 2 == 0) q0.push_back(w6); else q1.push_back(w6);
        end
        n = 0;
        for (int k = 0; k < 100 && (q0.size() > 0 || q1.size() > 0 || pend_v || exp_v); k++) begin
            cycle();
            if (push_D1) n++;
        end
        chk("wrap_pushes", n, 32);
        chk("wrap_cnt1", cnt_D1, 5'd0);
        chk("wrap_cnt0", cnt_D0, 5'd0);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(6'($urandom_range(0, 63)));
            almost_full_D0 = ($urandom_range(0, 3) == 0);
            almost_full_D1 = ($urandom_range(0, 3) == 0);
            cycle();
        end
        almost_full_D0 = 1'b0; almost_full_D1 = 1'b0;
        drain(80);

        // Asynchronous reset in the middle of a push
        q0.push_back(6'h05); q0.push_back(6'h15);
        n = 0;
        while (!(push_D0 || push_D1) && n < 10) begin cycle(); n++; end
        chk("mid_push_seen", (push_D0 || push_D1), 1'b1);
        reset = 1'b0;
        #1;
        chk("ar_push", {push_D0, push_D1}, 2'b00);
        chk("ar_data", {data_D0, data_D1}, 12'h000);
        chk("ar_cnt", {cnt_D0, cnt_D1}, 10'h000);
        chk("ar_idle", idle, 1'b0);
        chk("ar_pop", {pop_VC0, pop_VC1}, 2'b00);
        q0.delete(); q1.delete();
        clear_model();
        @(negedge clk);
        empty_VC0 = 1'b1; empty_VC1 = 1'b1;
        cycle();
        reset = 1'b1; init = 1'b0;
        cycle();
        init = 1'b1;
        cycle(); chk("ar_idle_after", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
